// File: rtl/key_click_classify.sv
// Groups debounced key pulses arriving within WIN ticks of each other into
// single/double/triple click events, emitted as registered one-cycle pulses.
module key_click_classify #(
    parameter int unsigned WIN        = 31,
    parameter int unsigned MAX_CLICKS = 3
) (
    input  logic       clk_8ms,
    input  logic       rst_n,
    input  logic       rst_sync,
    input  logic       key_pulse,
    output logic       busy,
    output logic       click_valid,
    output logic [1:0] click_cnt,
    output logic       single_click,
    output logic       double_click,
    output logic       triple_click
);

    localparam int unsigned TIMER_W = 8;
    localparam int unsigned CNT_W   = 2;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WIN - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(MAX_CLICKS);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    state_e             state_q;
    logic [TIMER_W-1:0] timer_q;
    logic [CNT_W-1:0]   clicks_q;

    logic               ev_c;
    logic [CNT_W-1:0]   ev_cnt_c;
    logic [CNT_W-1:0]   clicks_inc_c;

    // Decide whether this cycle closes a group, and with how many clicks.
    always_comb begin
        ev_c         = 1'b0;
        ev_cnt_c     = '0;
        clicks_inc_c = CNT_W'(clicks_q + CNT_W'(1));
        if (state_q == IDLE) begin
            if (key_pulse && (CNT_MAX == CNT_W'(1))) begin
                ev_c     = 1'b1;
                ev_cnt_c = CNT_W'(1);
            end
        end else begin
            if (key_pulse) begin
                if (clicks_inc_c == CNT_MAX) begin
                    ev_c     = 1'b1;
                    ev_cnt_c = CNT_MAX;
                end
            end else if (timer_q == TIMER_LAST) begin
                ev_c     = 1'b1;
                ev_cnt_c = clicks_q;
            end
        end
    end

    always_ff @(posedge clk_8ms or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            clicks_q     <= '0;
            busy         <= 1'b0;
            click_valid  <= 1'b0;
            click_cnt    <= '0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            triple_click <= 1'b0;
        end else if (rst_sync) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            clicks_q     <= '0;
            busy         <= 1'b0;
            click_valid  <= 1'b0;
            click_cnt    <= '0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            triple_click <= 1'b0;
        end else begin
            click_valid  <= ev_c;
            single_click <= ev_c && (ev_cnt_c == CNT_W'(1));
            double_click <= ev_c && (ev_cnt_c == CNT_W'(2));
            triple_click <= ev_c && (ev_cnt_c == CNT_W'(3));
            if (ev_c) begin
                click_cnt <= ev_cnt_c;
            end

            case (state_q)
                IDLE: begin
                    if (key_pulse && !ev_c) begin
                        state_q  <= WAIT;
                        busy     <= 1'b1;
                        clicks_q <= CNT_W'(1);
                        timer_q  <= '0;
                    end
                end
                WAIT: begin
                    if (ev_c) begin
                        state_q  <= IDLE;
                        busy     <= 1'b0;
                        clicks_q <= '0;
                        timer_q  <= '0;
                    end else if (key_pulse) begin
                        clicks_q <= clicks_inc_c;
                        timer_q  <= '0;
                    end else begin
                        timer_q  <= TIMER_W'(timer_q + TIMER_W'(1));
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
